ahb_lite_ram_slave: RTL and testbench

- AHB-Lite responder backed by on-chip register RAM, with configurable wait states and ERROR response generation.
- It is the target end of the bus that ahb_lite_rw_master drives. It is a drop-in replacement for ahb_lite_sdram in master-side testbenches and FPGA bring-up, so that master behaviour can be checked without the SDRAM model.
- Every beat is serviced individually; burst type is not used for timing.

---
 rtl/ahb_lite_ram_slave.sv | 202 ++++++++++++++++++++
 tb/tb_ahb_lite_ram_slave.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_ram_slave.sv
// ahb_lite_ram_slave
//   AHB-Lite responder backed by an on-chip word-organised register RAM.
//   Each OKAY data phase is stretched by WAIT_STATES HREADY-low cycles.
//   Illegal transfers (out of range, bad size, misaligned) get the
//   two-cycle ERROR response and never touch the RAM.
//
// Ports
//   HCLK     in   bus clock, rising edge
//   HRESETn  in   synchronous active-low reset
//   HADDR    in   [31:0] byte address (address phase)
//   HBURST   in   [2:0]  burst type, not used
//   HSEL     in   slave select (address phase)
//   HSIZE    in   [2:0]  0 = byte, 1 = half, 2 = word
//   HTRANS   in   [1:0]  IDLE/BUSY/NONSEQ/SEQ
//   HWDATA   in   [31:0] write data (data phase)
//   HWRITE   in   1 = write (address phase)
//   HRDATA   out  [31:0] read data, zero outside OKAY read data phases
//   HREADY   out  transfer complete / bus ready
//   HRESP    out  0 = OKAY, 1 = ERROR
module ahb_lite_ram_slave #(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [2:0]  HBURST,
    input  logic        HSEL,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {
        S_READY = 2'd0,
        S_WAIT  = 2'd1,
        S_ERR1  = 2'd2,
        S_ERR2  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  size_q, size_d;
    logic        write_q, write_d;
    logic        pend_q, pend_d;      // an OKAY transfer owns the current data phase
    logic        hready_q, hready_d;
    logic        hresp_q, hresp_d;

    logic [31:0] mem [MEM_WORDS];

    logic          accept_s;
    logic          acc_err_s;
    logic          commit_s;
    logic [AW-1:0] word_s;
    logic [3:0]    lanes_s;
    logic [31:0]   rdata_s;
    logic          unused_s;

    // Byte lanes touched by a transfer of the given size at the given offset.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] ofs);
        logic [3:0] m;
        case (size)
            3'd0:    m = 4'b0001 << ofs;
            3'd1:    m = ofs[1] ? 4'b1100 : 4'b0011;
            3'd2:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // A transfer is illegal when out of range, oversized or misaligned.
    function automatic logic xfer_err(input logic [31:0] a, input logic [2:0] s);
        logic e;
        e = ({2'b00, a[31:2]} >= 32'(MEM_WORDS));
        case (s)
            3'd0:    e = e;
            3'd1:    e = e | a[0];
            3'd2:    e = e | (a[1:0] != 2'b00);
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    assign accept_s  = hready_q & HSEL & HTRANS[1];
    assign acc_err_s = xfer_err(HADDR, HSIZE);
    // The write lands on the edge that ends its data phase.
    assign commit_s  = hready_q & pend_q & write_q;
    assign word_s    = addr_q[AW+1:2];
    assign lanes_s   = lane_mask(size_q, addr_q[1:0]);
    assign unused_s  = ^{HBURST, addr_q[31:AW+2]};

    assign HREADY = hready_q;
    assign HRESP  = hresp_q;
    assign HRDATA = rdata_s;

    // Read data is the latched word for the whole OKAY read data phase, else zero.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (pend_q && !write_q) begin
            rdata_s = mem[word_s];
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // Next-state and next-output computation for the response FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        size_d   = size_q;
        write_d  = write_q;
        pend_d   = pend_q;
        hready_d = 1'b1;
        hresp_d  = 1'b0;
        case (state_q)
            S_READY, S_ERR2: begin
                if (accept_s) begin
                    addr_d  = HADDR;
                    size_d  = HSIZE;
                    write_d = HWRITE;
                    if (acc_err_s) begin
                        state_d  = S_ERR1;
                        pend_d   = 1'b0;
                        hready_d = 1'b0;
                        hresp_d  = 1'b1;
                    end else if (WAIT_STATES > 0) begin
                        state_d  = S_WAIT;
                        cnt_d    = 4'(WAIT_STATES - 1);
                        pend_d   = 1'b1;
                        hready_d = 1'b0;
                    end else begin
                        state_d = S_READY;
                        pend_d  = 1'b1;
                    end
                end else begin
                    state_d = S_READY;
                    pend_d  = 1'b0;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_READY;
                end else begin
                    cnt_d    = cnt_q - 4'd1;
                    hready_d = 1'b0;
                end
            end
            S_ERR1: begin
                state_d = S_ERR2;
                pend_d  = 1'b0;
                hresp_d = 1'b1;
            end
            default: begin
                state_d = S_READY;
                pend_d  = 1'b0;
            end
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q  <= S_READY;
            cnt_q    <= 4'd0;
            addr_q   <= 32'h0000_0000;
            size_q   <= 3'd0;
            write_q  <= 1'b0;
            pend_q   <= 1'b0;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            write_q  <= write_d;
            pend_q   <= pend_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
        end
    end

    // RAM byte-lane write; contents survive reset, and a write pending during reset is dropped.
    always_ff @(posedge HCLK) begin
        if (HRESETn && commit_s) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes_s[i]) begin
                    mem[word_s][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_ram_slave.sv
// Bench for ahb_lite_ram_slave: three instances (0, 2 and 3 wait states)
// driven one at a time by a pipelined AHB master with random traffic,
// checked every cycle against a byte-array memory model and the response
// timing rules.
module tb_ahb_lite_ram_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        hresetn [3];
    logic [31:0] haddr   [3];
    logic [2:0]  hburst  [3];
    logic        hsel    [3];
    logic [2:0]  hsize   [3];
    logic [1:0]  htrans  [3];
    logic [31:0] hwdata  [3];
    logic        hwrite  [3];
    logic [31:0] hrdata  [3];
    logic        hready  [3];
    logic        hresp   [3];

    ahb_lite_ram_slave #(.MEM_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
        .HCLK(clk), .HRESETn(hresetn[0]), .HADDR(haddr[0]), .HBURST(hburst[0]),
        .HSEL(hsel[0]), .HSIZE(hsize[0]), .HTRANS(htrans[0]), .HWDATA(hwdata[0]),
        .HWRITE(hwrite[0]), .HRDATA(hrdata[0]), .HREADY(hready[0]), .HRESP(hresp[0]));

    ahb_lite_ram_slave #(.MEM_WORDS(1024), .WAIT_STATES(2)) u_ws2 (
        .HCLK(clk), .HRESETn(hresetn[1]), .HADDR(haddr[1]), .HBURST(hburst[1]),
        .HSEL(hsel[1]), .HSIZE(hsize[1]), .HTRANS(htrans[1]), .HWDATA(hwdata[1]),
        .HWRITE(hwrite[1]), .HRDATA(hrdata[1]), .HREADY(hready[1]), .HRESP(hresp[1]));

    ahb_lite_ram_slave #(.MEM_WORDS(1024), .WAIT_STATES(3)) u_ws3 (
        .HCLK(clk), .HRESETn(hresetn[2]), .HADDR(haddr[2]), .HBURST(hburst[2]),
        .HSEL(hsel[2]), .HSIZE(hsize[2]), .HTRANS(htrans[2]), .HWDATA(hwdata[2]),
        .HWRITE(hwrite[2]), .HRDATA(hrdata[2]), .HREADY(hready[2]), .HRESP(hresp[2]));

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t       q [$];
    logic [31:0] mdl [3][16];     // reference contents of words 0..15 per instance
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int ws_of(input int k);
        case (k)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic bit is_act(input xfer_t t);
        return t.sel && t.trans[1];
    endfunction

    function automatic bit is_err(input xfer_t t);
        bit e;
        e = (t.addr / 4) >= 1024;
        if (t.size > 2) e = 1'b1;
        if (t.size == 1 && (t.addr % 2) != 0) e = 1'b1;
        if (t.size == 2 && (t.addr % 4) != 0) e = 1'b1;
        return e;
    endfunction

    function automatic xfer_t idle_x();
        xfer_t t;
        t = '{1'b0, 2'd0, 1'b0, 32'd0, 3'd0, 32'd0};
        return t;
    endfunction

    task automatic push(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata);
        xfer_t t;
        t = '{1'b1, 2'd2, wr, addr, size, wdata};
        q.push_back(t);
    endtask

    task automatic push_rand();
        xfer_t t;
        int r;
        logic [31:0] m;
        r       = $urandom_range(0, 9);
        t.sel   = 1'b1;
        t.trans = 2'd2 + 2'($urandom_range(0, 1));
        t.wr    = 1'($urandom_range(0, 1));
        t.wdata = $urandom;
        t.size  = 3'($urandom_range(0, 2));
        t.addr  = 32'($urandom_range(0, 63));
        if (r == 0) begin
            t.trans = 2'($urandom_range(0, 1));
            t.sel   = 1'($urandom_range(0, 1));
            if (!t.sel) t.trans = 2'd2;
        end else if (r == 1) begin
            if ($urandom_range(0, 1) == 1) t.addr = 32'h0000_1000 + 32'($urandom_range(0, 63));
            else                           t.addr = $urandom | 32'h8000_0000;
        end else if (r == 2) begin
            t.size = 3'($urandom_range(3, 7));
        end else if (r <= 7) begin
            m = (32'd1 << t.size) - 32'd1;
            t.addr = t.addr & ~m;
        end
        q.push_back(t);
    endtask

    // Byte-wise update of the reference word for a legal write.
    task automatic mdl_write(input int k, input xfer_t t);
        int nb;
        int first;
        nb    = 1 << t.size;
        first = t.addr % 4;
        for (int i = first; i < first + nb; i++) begin
            mdl[k][(t.addr / 4) % 16][8*i +: 8] = t.wdata[8*i +: 8];
        end
    endtask

    task automatic drive_ap(input int k, input xfer_t t);
        hsel[k]   = t.sel;
        htrans[k] = t.trans;
        haddr[k]  = t.addr;
        hsize[k]  = t.size;
        hwrite[k] = t.wr;
        hburst[k] = 3'($urandom_range(0, 7));
    endtask

    // Pipelined master: drains q into instance k and checks each cycle.
    task automatic run(input int k);
        xfer_t       dp;
        xfer_t       ap;
        bit          dp_v;
        bit          dp_e;
        bit          rdy;
        int          dp_cyc;
        logic [31:0] er, ep, ed;
        string       pfx;
        pfx    = $sformatf("ws%0d", ws_of(k));
        dp_v   = 1'b0;
        dp_e   = 1'b0;
        dp_cyc = 0;
        dp     = idle_x();
        @(posedge clk);
        #1;
        ap = (q.size() != 0) ? q.pop_front() : idle_x();
        drive_ap(k, ap);
        hwdata[k] = $urandom;
        while (1) begin
            @(negedge clk);
            if (!dp_v) begin
                er = 32'd1; ep = 32'd0; ed = 32'd0;
            end else if (dp_e) begin
                er = (dp_cyc >= 1) ? 32'd1 : 32'd0; ep = 32'd1; ed = 32'd0;
            end else begin
                er = (dp_cyc >= ws_of(k)) ? 32'd1 : 32'd0;
                ep = 32'd0;
                ed = dp.wr ? 32'd0 : mdl[k][(dp.addr / 4) % 16];
            end
            check_eq({pfx, " hready"}, {31'd0, hready[k]}, er);
            check_eq({pfx, " hresp"},  {31'd0, hresp[k]},  ep);
            check_eq({pfx, " hrdata"}, hrdata[k], ed);
            rdy = hready[k];
            if (dp_v && dp_cyc > 20) begin
                check_eq({pfx, " data phase timeout"}, 32'(dp_cyc), 32'd0);
                drive_ap(k, idle_x());
                return;
            end
            if (rdy && !dp_v && !is_act(ap) && q.size() == 0) break;
            @(posedge clk);
            if (rdy) begin
                if (dp_v && !dp_e && dp.wr) mdl_write(k, dp);
                dp_v   = is_act(ap);
                dp     = ap;
                dp_e   = is_err(ap);
                dp_cyc = 0;
                ap     = (q.size() != 0) ? q.pop_front() : idle_x();
            end else begin
                dp_cyc++;
            end
            #1;
            drive_ap(k, ap);
            hwdata[k] = (dp_v && dp.wr) ? dp.wdata : $urandom;
        end
        drive_ap(k, idle_x());
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            hresetn[k] = 1'b0;
            hsel[k]    = 1'b1;
            htrans[k]  = 2'd2;
            haddr[k]   = 32'h0000_0000;
            hsize[k]   = 3'd2;
            hwrite[k]  = 1'b1;
            hwdata[k]  = 32'hFFFF_FFFF;
            hburst[k]  = 3'd0;
        end
        // Reset held for two cycles with a live NONSEQ on the bus.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (c > 0) begin
                for (int k = 0; k < 3; k++) begin
                    check_eq("reset hready", {31'd0, hready[k]}, 32'd1);
                    check_eq("reset hresp",  {31'd0, hresp[k]},  32'd0);
                    check_eq("reset hrdata", hrdata[k], 32'd0);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            hresetn[k] = 1'b1;
            drive_ap(k, idle_x());
        end

        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 16; w++) push(1'b1, 32'(4 * w), 3'd2, $urandom);
            push(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF);
            push(1'b0, 32'h10, 3'd2, 32'h0);
            push(1'b1, 32'h11, 3'd0, 32'h0000_AA00);
            push(1'b0, 32'h10, 3'd2, 32'h0);
            push(1'b1, 32'h12, 3'd1, 32'h1234_0000);
            push(1'b0, 32'h10, 3'd2, 32'h0);
            push(1'b0, 32'h20, 3'd2, 32'h0);
            push(1'b1, 32'h24, 3'd2, $urandom);
            push(1'b0, 32'h1000, 3'd2, 32'h0);
            push(1'b1, 32'h02, 3'd2, 32'hCAFE_F00D);
            push(1'b0, 32'h00, 3'd2, 32'h0);
            for (int i = 0; i < 150; i++) push_rand();
            for (int w = 0; w < 16; w++) push(1'b0, 32'(4 * w), 3'd2, 32'h0);
            run(k);
        end

        // Reset during the first wait cycle of a write on the 3-wait instance.
        @(posedge clk);
        #1;
        push(1'b1, 32'h30, 3'd2, 32'h0);
        drive_ap(2, q.pop_front());
        @(posedge clk);
        #1;
        drive_ap(2, idle_x());
        hwdata[2]  = 32'h55AA_55AA;
        hresetn[2] = 1'b0;
        @(negedge clk);
        check_eq("wait hready", {31'd0, hready[2]}, 32'd0);
        @(posedge clk);
        #1;
        hresetn[2] = 1'b1;
        @(negedge clk);
        check_eq("post-reset hready", {31'd0, hready[2]}, 32'd1);
        check_eq("post-reset hresp",  {31'd0, hresp[2]},  32'd0);
        check_eq("post-reset hrdata", hrdata[2], 32'd0);
        push(1'b0, 32'h30, 3'd2, 32'h0);
        run(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
